// File: rtl/async_fifo_wr_arbiter.sv
// rtl/async_fifo_wr_arbiter.sv - round-robin burst arbiter for the write port of an async FIFO
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_BURST    = 4,
  parameter int HOLD_TIMEOUT = 8,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int BCW = $clog2(MAX_BURST + 1),
  localparam int ICW = $clog2(HOLD_TIMEOUT + 1)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id,
  output logic                          burst_done
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;
  logic            burst_done_q, burst_done_d;

  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  int              scan_idx;
  logic            beat;
  logic            release_grant;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign grant_valid = (state_q == BURST);
  assign grant_id    = grant_id_q;
  assign burst_done  = burst_done_q;

  // Round-robin scan: first valid requester after the last one served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      scan_idx = int'(rr_ptr_q) + off;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!pick_found && req_valid[IDW'(scan_idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(scan_idx);
      end
    end
  end

  // Next-state and combinational handshake/data path to the FIFO.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    beat_cnt_d    = beat_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    burst_done_d  = 1'b0;
    req_ready     = '0;
    fifo_wr_en    = 1'b0;
    fifo_wr_data  = '0;
    beat          = 1'b0;
    release_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          rr_ptr_d   = pick_idx;
          state_d    = BURST;
        end
      end
      BURST: begin
        req_ready[grant_id_q] = ~fifo_full;
        beat                  = req_valid[grant_id_q] & ~fifo_full;
        fifo_wr_en            = beat;
        fifo_wr_data          = data_arr[grant_id_q];
        if (beat) begin
          idle_cnt_d = '0;
          if (req_last[grant_id_q] || (beat_cnt_q == BCW'(MAX_BURST - 1))) begin
            release_grant = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end else if (!req_valid[grant_id_q]) begin
          // A stall (full with valid held) keeps both counters frozen.
          if (idle_cnt_q == ICW'(HOLD_TIMEOUT - 1)) begin
            release_grant = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + ICW'(1);
          end
        end
        if (release_grant) begin
          state_d      = IDLE;
          beat_cnt_d   = '0;
          idle_cnt_d   = '0;
          burst_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any partial burst.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      burst_done_q <= burst_done_d;
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb/tb_async_fifo_wr_arbiter.sv - randomized scoreboard bench for async_fifo_wr_arbiter
module tb_async_fifo_wr_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int MB  = 4;
  localparam int HT  = 8;
  localparam int IDW = $clog2(NR);

  logic              wr_clk = 1'b0;
  logic              wr_rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;
  logic              burst_done;

  async_fifo_wr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .HOLD_TIMEOUT(HT)
  ) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_valid(grant_valid), .grant_id(grant_id), .burst_done(burst_done)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic          rst;
    logic          gv;
    logic [IDW-1:0] gid;
    logic [NR-1:0] rdy;
    logic          wen;
    logic          done;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] wr_q [$];
  logic [DW:0]   src_q [NR][$];

  int vectors = 0;
  int miscompares = 0;

  // reference model: who holds the port, who was served last, beats/quiet cycles in this grant
  int m_holder = -1;
  int m_last = NR - 1;
  int m_beats = 0;
  int m_quiet = 0;
  bit m_done = 1'b0;

  int quiet_left [NR];
  bit gate_en = 1'b0;
  bit full_rand = 1'b0;
  bit refill_en = 1'b0;
  int full_left = 0;
  int seq = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int r, input int len, input bit with_last);
    for (int k = 0; k < len; k++) begin
      seq++;
      src_q[r].push_back({(with_last && (k == len - 1)), DW'((r << 12) | (seq & 'hfff))});
    end
  endtask

  task automatic cycle(input bit rst_val, input bit full_force);
    exp_t e;
    int   g;
    int   c;
    bit   rel;
    bit   lst;
    @(negedge wr_clk);
    wr_rst_n = rst_val;
    if (refill_en)
      for (int i = 0; i < NR; i++)
        if (src_q[i].size() < 2 && $urandom_range(0, 3) == 0)
          push_burst(i, $urandom_range(1, 7), $urandom_range(0, 3) != 0);
    if (full_rand) begin
      if (full_left > 0) full_left--;
      else if ($urandom_range(0, 9) == 0) full_left = $urandom_range(1, 6);
      fifo_full = (full_left > 0);
    end else begin
      fifo_full = full_force;
    end
    for (int i = 0; i < NR; i++) begin
      if (gate_en) begin
        if (quiet_left[i] > 0) quiet_left[i]--;
        else if ($urandom_range(0, 11) == 0) quiet_left[i] = $urandom_range(1, 12);
      end else begin
        quiet_left[i] = 0;
      end
      req_valid[i] = (src_q[i].size() > 0) && (quiet_left[i] == 0);
      if (src_q[i].size() > 0) begin
        req_last[i]           = src_q[i][0][DW];
        req_data[i*DW +: DW]  = src_q[i][0][DW-1:0];
      end else begin
        req_last[i]           = 1'($urandom_range(0, 1));
        req_data[i*DW +: DW]  = DW'($urandom);
      end
    end
    e   = '0;
    rel = 1'b0;
    if (!rst_val) begin
      e.rst    = 1'b1;
      m_holder = -1;
      m_last   = NR - 1;
      m_beats  = 0;
      m_quiet  = 0;
      m_done   = 1'b0;
    end else begin
      e.done = m_done;
      m_done = 1'b0;
      if (m_holder < 0) begin
        for (int k = 1; k <= NR; k++) begin
          c = (m_last + k) % NR;
          if (m_holder < 0 && req_valid[c]) m_holder = c;
        end
        if (m_holder >= 0) m_last = m_holder;
      end else begin
        g     = m_holder;
        e.gv  = 1'b1;
        e.gid = IDW'(g);
        if (!fifo_full) e.rdy[g] = 1'b1;
        if (req_valid[g] && !fifo_full) begin
          e.wen = 1'b1;
          wr_q.push_back(src_q[g][0][DW-1:0]);
          lst = src_q[g][0][DW];
          void'(src_q[g].pop_front());
          m_beats++;
          m_quiet = 0;
          if (lst || m_beats == MB) rel = 1'b1;
        end else if (!req_valid[g]) begin
          m_quiet++;
          if (m_quiet == HT) rel = 1'b1;
        end
        if (rel) begin
          m_holder = -1;
          m_beats  = 0;
          m_quiet  = 0;
          m_done   = 1'b1;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares every cycle's outputs, and the FIFO word whenever one is expected.
  initial begin
    exp_t          e;
    logic [DW-1:0] d;
    forever begin
      @(negedge wr_clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("grant_valid", 32'(grant_valid), 32'(e.gv));
        if (e.gv || e.rst) chk("grant_id", 32'(grant_id), 32'(e.gid));
        chk("req_ready", 32'(req_ready), 32'(e.rdy));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e.wen));
        chk("burst_done", 32'(burst_done), 32'(e.done));
        if (e.rst) chk("fifo_wr_data_rst", 32'(fifo_wr_data), 32'd0);
        if (e.wen) begin
          d = wr_q.pop_front();
          if (fifo_wr_en) chk("fifo_wr_data", 32'(fifo_wr_data), 32'(d));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) quiet_left[i] = 0;
    // single 3-word burst from requester 0 straight out of reset
    push_burst(0, 3, 1);
    repeat (2) cycle(1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0);
    // every requester with single-word bursts: strict rotation with bubbles
    for (int r = 0; r < NR; r++) begin
      push_burst(r, 1, 1);
      push_burst(r, 1, 1);
    end
    repeat (26) cycle(1'b1, 1'b0);
    // lone requester with 6 unterminated words, FIFO full for 5 cycles mid-burst
    push_burst(2, 6, 0);
    for (int k = 0; k < 30; k++) cycle(1'b1, (k >= 3 && k < 8));
    // holder goes silent after one beat while another requester waits
    push_burst(1, 1, 0);
    repeat (2) cycle(1'b1, 1'b0);
    push_burst(3, 1, 1);
    repeat (16) cycle(1'b1, 1'b0);
    // randomized traffic, gaps and backpressure
    gate_en = 1'b1;
    full_rand = 1'b1;
    refill_en = 1'b1;
    repeat (4000) cycle(1'b1, 1'b0);
    gate_en = 1'b0;
    full_rand = 1'b0;
    refill_en = 1'b0;
    repeat (150) cycle(1'b1, 1'b0);
    // reset pulse in the middle of a burst
    push_burst(1, 8, 1);
    push_burst(3, 2, 1);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b0);
      if (m_holder == 1 && m_beats >= 2) break;
    end
    cycle(1'b0, 1'b0);
    push_burst(2, 2, 1);
    repeat (150) cycle(1'b1, 1'b0);
    #3;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
